uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, frame FSM encoding and parity helper.
// uart_tx uses them now; uart_rx reuses the same oversampling and parity definitions.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned MAX_DBITS  = 9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DBITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s),
// timed by the shared 16x oversampling strobe s_ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBITS   = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PAR_EN  = 0,
  parameter int unsigned PAR_ODD = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_ticks,
  input  logic             tx_start,
  input  logic [DBITS-1:0] tx_din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_ticks
);

  localparam int unsigned TICK_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned BIT_W  = $clog2(DBITS);

  uart_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DBITS-1:0]  shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic              stop_end;
  logic              last_data;

  assign bit_end   = s_ticks && (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign stop_end  = s_ticks && (tick_q == TICK_W'(SB_TICK - 1));
  assign last_data = (bit_q == BIT_W'(DBITS - 1));

  // State and datapath registers; reset abandons any frame and idles the line high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counters and next line level.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = tx_din;
          par_d   = parity_bit(MAX_DBITS'(tx_din), (PAR_ODD != 0));
          tick_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else if (s_ticks) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (last_data) begin
            state_d = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else if (s_ticks) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = ST_STOP;
        end else if (s_ticks) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_STOP: begin
        if (stop_end) begin
          tick_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (s_ticks) begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Line level follows the state being entered, so tx changes on the same edge.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx            = tx_q;
  assign tx_busy       = busy_q;
  assign tx_done_ticks = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants driven from one tick source and
// checked tick-by-tick against a frame-level model of the serial line.
module tb_uart_tx;

  localparam int NI = 4;
  localparam int DB [NI] = '{8, 8, 8, 9};
  localparam int PE [NI] = '{0, 1, 1, 0};
  localparam int PO [NI] = '{0, 0, 1, 0};
  localparam int SB [NI] = '{16, 32, 24, 16};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_ticks = 1'b0;
  logic [NI-1:0] tx_start_v;
  logic [8:0]    din_v [NI];
  logic [NI-1:0] tx_v, busy_v, done_v;

  int n_checks = 0;
  int n_errors = 0;
  bit tick_rand = 1'b0;
  int tick_gap = 0;

  uart_tx #(.DBITS(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u0 (
    .clk(clk), .reset_n(reset_n), .s_ticks(s_ticks), .tx_start(tx_start_v[0]),
    .tx_din(din_v[0][7:0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_ticks(done_v[0]));
  uart_tx #(.DBITS(8), .SB_TICK(32), .PAR_EN(1), .PAR_ODD(0)) u1 (
    .clk(clk), .reset_n(reset_n), .s_ticks(s_ticks), .tx_start(tx_start_v[1]),
    .tx_din(din_v[1][7:0]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_ticks(done_v[1]));
  uart_tx #(.DBITS(8), .SB_TICK(24), .PAR_EN(1), .PAR_ODD(1)) u2 (
    .clk(clk), .reset_n(reset_n), .s_ticks(s_ticks), .tx_start(tx_start_v[2]),
    .tx_din(din_v[2][7:0]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_ticks(done_v[2]));
  uart_tx #(.DBITS(9), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u3 (
    .clk(clk), .reset_n(reset_n), .s_ticks(s_ticks), .tx_start(tx_start_v[3]),
    .tx_din(din_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_ticks(done_v[3]));

  always #5 clk = ~clk;

  // Oversampling strobe: fixed every 4 clk, or random spacing of 1..4 clk.
  always @(posedge clk) begin
    #1;
    if (tick_gap == 0) begin
      s_ticks  = 1'b1;
      tick_gap = tick_rand ? int'($urandom_range(0, 3)) : 3;
    end else begin
      s_ticks = 1'b0;
      tick_gap--;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len(input int i);
    return (1 + DB[i] + PE[i]) * 16 + SB[i];
  endfunction

  // Expected line level during the k-th counted tick of a frame carrying d.
  function automatic logic exp_level(input int i, input logic [8:0] d, input int k);
    int b;
    logic [8:0] mask;
    b = k / 16;
    if (b == 0) return 1'b0;
    b = b - 1;
    if (b < DB[i]) return d[b];
    mask = 9'((1 << DB[i]) - 1);
    if (PE[i] != 0 && b == DB[i]) return (^(d & mask)) ^ (PO[i] != 0);
    return 1'b1;
  endfunction

  // Called and returns on a falling edge. keep leaves tx_start high for a back-to-back frame.
  task automatic send(input int i, input logic [8:0] d, input bit keep, input bit sync_tick,
                      input bit pulse_busy);
    int total;
    int k;
    int budget;
    total = frame_len(i);
    k = 0;
    budget = 0;
    if (sync_tick) begin
      while (!s_ticks && budget < 16) begin
        @(negedge clk);
        budget++;
      end
    end
    tx_start_v[i] = 1'b1;
    din_v[i] = d;
    @(negedge clk);
    check_eq("accept_tx", 32'(tx_v[i]), 32'd0);
    check_eq("accept_busy", 32'(busy_v[i]), 32'd1);
    tx_start_v[i] = keep;
    din_v[i] = 9'($urandom);
    budget = 0;
    while (1) begin
      if (s_ticks) begin
        check_eq($sformatf("tx_u%0d_k%0d", i, k), 32'(tx_v[i]), 32'(exp_level(i, d, k)));
        check_eq("busy_done_in_frame", 32'({busy_v[i], done_v[i]}), 32'd2);
        k++;
      end
      if (pulse_busy && !keep) tx_start_v[i] = ($urandom_range(0, 7) == 0);
      if (k == total) break;
      @(negedge clk);
      budget++;
      if (budget > total * 8 + 64) begin
        check_eq("frame_timeout", 32'd0, 32'd1);
        tx_start_v[i] = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(done_v[i]), 32'd1);
    check_eq("done_busy", 32'(busy_v[i]), 32'd0);
    check_eq("done_tx", 32'(tx_v[i]), 32'd1);
    tx_start_v[i] = keep;
    if (!keep) begin
      @(negedge clk);
      check_eq("idle_after_done", 32'({tx_v[i], busy_v[i], done_v[i]}), 32'd4);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] d;
    int i;
    int k;
    bit keep;
    bit prev_keep;
    bit seen_done;

    reset_n = 1'b0;
    tx_start_v = '0;
    for (int n = 0; n < NI; n++) din_v[n] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_tx", 32'(tx_v), 32'hF);
    check_eq("reset_busy_done", 32'({busy_v, done_v}), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", 32'({tx_v, busy_v, done_v}), 32'hF00);

    // Directed frames with a regular tick every 4 clk.
    send(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send(1, 9'h007, 1'b0, 1'b0, 1'b0);
    send(2, 9'h007, 1'b0, 1'b1, 1'b0);
    send(3, 9'h1A5, 1'b0, 1'b0, 1'b0);
    send(0, 9'h055, 1'b1, 1'b0, 1'b0);
    send(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    send(1, 9'h03C, 1'b0, 1'b1, 1'b1);

    // Reset during data bit 0 of an all-zero word.
    tx_start_v[0] = 1'b1;
    din_v[0] = 9'h000;
    @(negedge clk);
    tx_start_v[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 400 && k < 24; c++) begin
      if (s_ticks) k++;
      if (k < 24) @(negedge clk);
    end
    check_eq("pre_reset_tx_low", 32'(tx_v[0]), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_reset_line", 32'({tx_v[0], busy_v[0]}), 32'd2);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done_v != '0 || busy_v != '0 || tx_v != 4'hF) seen_done = 1'b1;
    end
    check_eq("quiet_after_reset", 32'(seen_done), 32'd0);
    send(0, 9'h0A5, 1'b0, 1'b0, 1'b0);

    // Randomized frames, tick spacing and back-to-back requests.
    tick_rand = 1'b1;
    prev_keep = 1'b0;
    i = 0;
    for (int it = 0; it < 40; it++) begin
      if (!prev_keep) i = $urandom_range(0, NI - 1);
      d = 9'($urandom);
      keep = ($urandom_range(0, 3) == 0) && (it < 39);
      send(i, d, keep, !prev_keep && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
      prev_keep = keep;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
